// File: rtl/pyc_fifo_flow.sv
// pyc_fifo_flow: parametrised ready/valid elastic buffer
// any depth, occupancy count, threshold flags, flush, peak monitor
module pyc_fifo_flow #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    peak,
    input  logic             peak_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AE_LVL = CW'(AEMPTY_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic [CW-1:0]    peak_nxt;
    logic             push;
    logic             pop;

    // Handshake and flags come from registered state only (plus flush).
    assign in_ready     = (count != FULL) && !flush;
    assign out_valid    = (count != '0);
    assign out_data     = out_valid ? mem[rd_ptr] : '0;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready && !flush;

    // Pointer wrap is by compare so non-power-of-2 depths work.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (push) begin
            wr_ptr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Next occupancy and high-water mark; flush leaves peak alone.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
        if (peak_clr) begin
            peak_nxt = count_nxt;
        end else if (count_nxt > peak) begin
            peak_nxt = count_nxt;
        end else begin
            peak_nxt = peak;
        end
    end

    // Control state; reset drops every entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            peak   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            peak   <= peak_nxt;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            peak   <= peak_nxt;
        end
    end

    // Storage needs no reset: reads are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_pyc_fifo_flow.sv
// tb_pyc_fifo_flow: directed vectors for pyc_fifo_flow
// DEPTH=5 WIDTH=8 AFULL_LEVEL=3 AEMPTY_LEVEL=1
module tb_pyc_fifo_flow;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [2:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] peak;
    logic       peak_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    pyc_fifo_flow #(
        .WIDTH(8),
        .DEPTH(5),
        .AFULL_LEVEL(3),
        .AEMPTY_LEVEL(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .peak(peak),
        .peak_clr(peak_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       pc;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        int         cnt;
        logic       af;
        logic       ae;
        int         pk;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv,
                         input logic [7:0] d, input logic ordy,
                         input logic pc);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        peak_clr  = pc;
    endtask

    task automatic exp_all(input string t, input logic ir,
                           input logic ov, input logic [7:0] od,
                           input int cnt, input logic af,
                           input logic ae, input int pk);
        chk({t, ".in_ready"}, int'(in_ready), int'(ir));
        chk({t, ".out_valid"}, int'(out_valid), int'(ov));
        chk({t, ".out_data"}, int'(out_data), int'(od));
        chk({t, ".count"}, int'(count), cnt);
        chk({t, ".almost_full"}, int'(almost_full), int'(af));
        chk({t, ".almost_empty"}, int'(almost_empty), int'(ae));
        chk({t, ".peak"}, int'(peak), pk);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fl iv d ordy pc | ir ov od cnt af ae pk
        vt[0]  = '{0, 1, 8'h11, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0};
        vt[1]  = '{0, 1, 8'h12, 0, 0, 1, 1, 8'h11, 1, 0, 1, 1};
        vt[2]  = '{0, 1, 8'h13, 0, 0, 1, 1, 8'h11, 2, 0, 0, 2};
        vt[3]  = '{0, 1, 8'h14, 0, 0, 1, 1, 8'h11, 3, 1, 0, 3};
        vt[4]  = '{0, 1, 8'h15, 0, 0, 1, 1, 8'h11, 4, 1, 0, 4};
        vt[5]  = '{0, 1, 8'h99, 0, 0, 0, 1, 8'h11, 5, 1, 0, 5};
        vt[6]  = '{0, 0, 8'h00, 1, 0, 0, 1, 8'h11, 5, 1, 0, 5};
        vt[7]  = '{0, 0, 8'h00, 1, 0, 1, 1, 8'h12, 4, 1, 0, 5};
        vt[8]  = '{0, 0, 8'h00, 1, 0, 1, 1, 8'h13, 3, 1, 0, 5};
        vt[9]  = '{0, 0, 8'h00, 0, 1, 1, 1, 8'h14, 2, 0, 0, 5};
        vt[10] = '{0, 0, 8'h00, 1, 0, 1, 1, 8'h14, 2, 0, 0, 2};
        vt[11] = '{0, 0, 8'h00, 1, 0, 1, 1, 8'h15, 1, 0, 1, 2};
        vt[12] = '{0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 2};

        #1 rst = 1'b0;
        #2;
        exp_all("reset", 1, 0, 8'h00, 0, 0, 1, 0);
        tick;
        exp_all("reset_edge", 1, 0, 8'h00, 0, 0, 1, 0);
        #2 rst = 1'b1;
        tick;

        // fill, reject, drain, thresholds, peak_clr
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].fl, vt[i].iv, vt[i].d, vt[i].ordy, vt[i].pc);
            #1;
            exp_all($sformatf("v%0d", i), vt[i].ir, vt[i].ov,
                    vt[i].od, vt[i].cnt, vt[i].af, vt[i].ae,
                    vt[i].pk);
            tick;
        end

        // full with simultaneous push and pop
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 8'(8'h21 + i), 0, 0);
            tick;
        end
        drive(0, 1, 8'h26, 1, 0);
        #1;
        chk("full.in_ready", int'(in_ready), 0);
        chk("full.out_data", int'(out_data), 8'h21);
        chk("full.count", int'(count), 5);
        tick;
        drive(0, 1, 8'h26, 0, 0);
        #1;
        chk("full.count_after_pop", int'(count), 4);
        chk("full.in_ready_again", int'(in_ready), 1);
        tick;
        drive(0, 0, 8'h00, 1, 0);
        #1;
        chk("full.refill_count", int'(count), 5);
        chk("full.peak", int'(peak), 5);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("full.drain%0d", i), int'(out_data),
                8'h22 + i);
            tick;
        end
        drive(0, 0, 8'h00, 0, 0);
        #1;
        chk("full.empty", int'(count), 0);

        // flush with push and pop requested
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'(8'h31 + i), 0, 0);
            tick;
        end
        drive(1, 1, 8'h34, 1, 0);
        #1;
        chk("flush.count_before", int'(count), 3);
        chk("flush.in_ready", int'(in_ready), 0);
        tick;
        drive(0, 1, 8'h44, 0, 0);
        #1;
        exp_all("flush.after", 1, 0, 8'h00, 0, 0, 1, 5);
        tick;
        drive(0, 0, 8'h00, 1, 0);
        #1;
        chk("flush.new_valid", int'(out_valid), 1);
        chk("flush.new_data", int'(out_data), 8'h44);
        tick;
        drive(0, 0, 8'h00, 0, 0);
        #1;
        chk("flush.empty", int'(count), 0);

        // streaming through the wrap point
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 8'(i), 1, 0);
            #1;
            if (i == 0) begin
                chk("wrap.first_valid", int'(out_valid), 0);
            end else begin
                chk($sformatf("wrap.data%0d", i - 1),
                    int'(out_data), i - 1);
                chk($sformatf("wrap.count%0d", i), int'(count), 1);
            end
            tick;
        end
        drive(0, 0, 8'h00, 1, 0);
        #1;
        chk("wrap.last", int'(out_data), 8'h1f);
        tick;
        drive(0, 0, 8'h00, 0, 0);
        #1;
        chk("wrap.empty", int'(count), 0);

        // async reset in the middle of a burst
        drive(0, 1, 8'h51, 0, 0);
        tick;
        drive(0, 1, 8'h52, 0, 0);
        tick;
        #1;
        chk("arst.pre_count", int'(count), 2);
        #1 rst = 1'b0;
        #1;
        drive(0, 0, 8'h00, 0, 0);
        #1;
        exp_all("arst.now", 1, 0, 8'h00, 0, 0, 1, 0);
        tick;
        #2 rst = 1'b1;
        drive(0, 1, 8'ha5, 0, 0);
        #1;
        exp_all("arst.release", 1, 0, 8'h00, 0, 0, 1, 0);
        tick;
        drive(0, 0, 8'h00, 0, 0);
        #1;
        chk("arst.a5_valid", int'(out_valid), 1);
        chk("arst.a5_data", int'(out_data), 8'ha5);
        chk("arst.a5_count", int'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
